// File: rtl/frame_scheduler.sv
// Frame pacing / latch sequencer for the LED string drivers on clk_20.
// Optional STREAM watchdog enabled by defining FRAME_SCHED_TIMEOUT_EN.
module frame_scheduler #(
   parameter int unsigned FIFO_ADDR_WIDTH = 13,
   parameter int unsigned FRAME_WORDS     = 1200,
   parameter int unsigned LATCH_CYCLES    = 1200,
   parameter int unsigned STREAM_TIMEOUT  = 65535
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       enable,
   input  logic [23:0]                frame_period,
   input  logic [FIFO_ADDR_WIDTH:0]   fifo_full_count,
   input  logic                       string_active,
   output logic                       start_frame,
   output logic                       h_blank,
   output logic                       busy,
   output logic [1:0]                 state,
   output logic [15:0]                frame_count,
   output logic [7:0]                 late_count,
   output logic                       timeout_err
);

   localparam int unsigned CNT_W = FIFO_ADDR_WIDTH + 1;
   localparam int unsigned LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
   localparam logic [CNT_W:0]   FRAME_WORDS_EXT = (CNT_W + 1)'(FRAME_WORDS);
   localparam logic [LAT_W-1:0] LATCH_LOAD      = LAT_W'(LATCH_CYCLES - 1);

   if (FRAME_WORDS > (64'd1 << FIFO_ADDR_WIDTH)) begin : g_bad_frame_words
      $error("frame_scheduler: FRAME_WORDS exceeds FIFO capacity");
   end
   if (LATCH_CYCLES < 1) begin : g_bad_latch
      $error("frame_scheduler: LATCH_CYCLES must be at least 1");
   end
   if (STREAM_TIMEOUT < 1) begin : g_bad_timeout
      $error("frame_scheduler: STREAM_TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_STREAM = 2'd2,
      S_LATCH  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [23:0]      period_cnt_q, period_cnt_d;
   logic [LAT_W-1:0] latch_cnt_q, latch_cnt_d;
   logic             pend_q, pend_d;
   logic             seen_q, seen_d;
   logic             start_q, start_d;
   logic             h_blank_q, h_blank_d;
   logic             busy_q, busy_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic [7:0]       late_q, late_d;
   logic             tick_c;
   logic             frame_ready_c;

`ifdef FRAME_SCHED_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(STREAM_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(STREAM_TIMEOUT - 1);

   logic [TO_W-1:0]  stream_cnt_q, stream_cnt_d;
   logic             timeout_q, timeout_d;
   logic             skip_q, skip_d;
`endif

   assign tick_c        = enable && (period_cnt_q == 24'd0);
   assign frame_ready_c = {1'b0, fifo_full_count} >= FRAME_WORDS_EXT;

   // Next-state and next-output logic; every register gets its hold value first.
   always_comb begin
      state_d      = state_q;
      period_cnt_d = period_cnt_q;
      latch_cnt_d  = latch_cnt_q;
      pend_d       = pend_q;
      seen_d       = seen_q;
      start_d      = 1'b0;
      h_blank_d    = h_blank_q;
      frame_cnt_d  = frame_cnt_q;
      late_d       = late_q;
`ifdef FRAME_SCHED_TIMEOUT_EN
      stream_cnt_d = stream_cnt_q;
      timeout_d    = timeout_q;
      skip_d       = skip_q;
`endif

      if (!enable) begin
         period_cnt_d = 24'd0;
      end else if (tick_c) begin
         period_cnt_d = (frame_period <= 24'd1) ? 24'd0 : frame_period - 24'd1;
      end else begin
         period_cnt_d = period_cnt_q - 24'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (enable && (tick_c || pend_q)) begin
               state_d = S_WAIT;
               pend_d  = 1'b0;
            end
         end

         S_WAIT: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (frame_ready_c) begin
               state_d = S_STREAM;
               start_d = 1'b1;
               seen_d  = string_active;
`ifdef FRAME_SCHED_TIMEOUT_EN
               stream_cnt_d = '0;
               skip_d       = 1'b0;
`endif
            end else if (tick_c && (late_q != 8'hFF)) begin
               late_d = late_q + 8'd1;
            end
         end

         S_STREAM: begin
            if (string_active) begin
               seen_d = 1'b1;
            end
            if (seen_q && !string_active) begin
               state_d     = S_LATCH;
               h_blank_d   = 1'b1;
               latch_cnt_d = LATCH_LOAD;
            end
`ifdef FRAME_SCHED_TIMEOUT_EN
            // Watchdog: stuck string driver still gets a latch, but the frame is not counted.
            else if (stream_cnt_q == TO_LAST) begin
               state_d     = S_LATCH;
               h_blank_d   = 1'b1;
               latch_cnt_d = LATCH_LOAD;
               timeout_d   = 1'b1;
               skip_d      = 1'b1;
            end else begin
               stream_cnt_d = stream_cnt_q + TO_W'(1);
            end
`endif
         end

         S_LATCH: begin
            if (tick_c) begin
               pend_d = 1'b1;
            end
            if (latch_cnt_q == '0) begin
               state_d   = S_IDLE;
               h_blank_d = 1'b0;
`ifdef FRAME_SCHED_TIMEOUT_EN
               if (!skip_q) begin
                  frame_cnt_d = frame_cnt_q + 16'd1;
               end
`else
               frame_cnt_d = frame_cnt_q + 16'd1;
`endif
            end else begin
               latch_cnt_d = latch_cnt_q - LAT_W'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase

      if (!enable) begin
         pend_d = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         period_cnt_q <= '0;
         latch_cnt_q  <= '0;
         pend_q       <= 1'b0;
         seen_q       <= 1'b0;
         start_q      <= 1'b0;
         h_blank_q    <= 1'b0;
         busy_q       <= 1'b0;
         frame_cnt_q  <= '0;
         late_q       <= '0;
      end else begin
         state_q      <= state_d;
         period_cnt_q <= period_cnt_d;
         latch_cnt_q  <= latch_cnt_d;
         pend_q       <= pend_d;
         seen_q       <= seen_d;
         start_q      <= start_d;
         h_blank_q    <= h_blank_d;
         busy_q       <= busy_d;
         frame_cnt_q  <= frame_cnt_d;
         late_q       <= late_d;
      end
   end

`ifdef FRAME_SCHED_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stream_cnt_q <= '0;
         timeout_q    <= 1'b0;
         skip_q       <= 1'b0;
      end else begin
         stream_cnt_q <= stream_cnt_d;
         timeout_q    <= timeout_d;
         skip_q       <= skip_d;
      end
   end

   assign timeout_err = timeout_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign start_frame = start_q;
   assign h_blank     = h_blank_q;
   assign busy        = busy_q;
   assign state       = state_q;
   assign frame_count = frame_cnt_q;
   assign late_count  = late_q;

endmodule
